// File: rtl/i2c_shift_datapath.sv
// Bit-level I2C datapath: word serialise/deserialise, ACK drive/capture and START/STOP/RSTART edges.
// Optional SDA input filter is built when I2C_DP_RX_FILTER_EN is defined.
module i2c_shift_datapath #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 8
) (
    input  logic                         i2c_core_clock_i,
    input  logic                         reset_bit_i,
    input  logic                         sda_i,
    input  logic [3:0]                   phase_i,
    input  logic [DATA_W-1:0]            addr_rw_i,
    input  logic [DATA_W-1:0]            tx_data_i,
    input  logic                         ack_bit_i,
    input  logic [PRESC_W:0]             edge_cnt_i,
    input  logic [PRESC_W-1:0]           prescaler_i,
    output logic                         sda_o,
    output logic [DATA_W-1:0]            rx_data_o,
    output logic                         rx_valid_o,
    output logic                         ack_rx_o,
    output logic [$clog2(DATA_W+1)-1:0]  bit_cnt_o,
    output logic                         phase_done_o
);

    localparam int CNT_W = $clog2(DATA_W+1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = '0;
    localparam logic [PRESC_W:0]   P_ONE    = (PRESC_W+1)'(1);

    typedef enum logic [3:0] {
        PH_IDLE   = 4'd0,
        PH_START  = 4'd1,
        PH_WADDR  = 4'd2,
        PH_WDATA  = 4'd3,
        PH_RDATA  = 4'd4,
        PH_WACK   = 4'd5,
        PH_RACK   = 4'd6,
        PH_STOP   = 4'd7,
        PH_RSTART = 4'd8
    } phase_e;

    phase_e              ph;
    logic [3:0]          phase_q;
    logic                entry;
    logic [PRESC_W:0]    p_val;
    logic                t_drv;
    logic                t_smp;
    logic                sda_s;

    logic [DATA_W-1:0]   tx_sr;
    logic [DATA_W-1:0]   rx_sr;
    logic                fin_q;

    logic [CNT_W-1:0]    cnt_base;
    logic [DATA_W-1:0]   tx_base;
    logic [DATA_W-1:0]   rx_base;
    logic                fin_base;
    logic                cnt_live;
    logic                cnt_last;
    logic [DATA_W-1:0]   rx_shift;

`ifdef I2C_DP_RX_FILTER_EN
    logic [1:0] sync_q;
    logic [2:0] maj_q;

    // Line idles high, so the filter starts released to avoid a false low sample.
    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
        if (!reset_bit_i) begin
            sync_q <= 2'b11;
            maj_q  <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], sda_i};
            maj_q  <= {maj_q[1:0], sync_q[1]};
        end
    end

    assign sda_s = (maj_q[0] & maj_q[1]) | (maj_q[1] & maj_q[2]) | (maj_q[0] & maj_q[2]);
`else
    assign sda_s = sda_i;
`endif

    // Codes above RSTART collapse onto IDLE so every action case stays exhaustive.
    always_comb begin
        if (phase_i <= 4'd8) ph = phase_e'(phase_i);
        else                 ph = PH_IDLE;
    end

    // Prescaler 0 behaves as 1; the counter width leaves room for 2P-1 without wrap.
    always_comb begin
        p_val = (prescaler_i == '0) ? P_ONE : {1'b0, prescaler_i};
        t_drv = (edge_cnt_i == p_val - P_ONE);
        t_smp = (edge_cnt_i == (p_val << 1) - P_ONE);
    end

    assign entry = (phase_i != phase_q);

    // Entry load is folded into the base values so a coincident drive/sample point
    // acts on the freshly loaded word and count in the same cycle.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_base = bit_cnt_o;
        tx_base  = tx_sr;
        rx_base  = rx_sr;
        fin_base = fin_q;
        if (entry) begin
            fin_base = 1'b0;
            case (ph)
                PH_WADDR: begin
                    tx_base  = addr_rw_i;
                    cnt_base = CNT_FULL;
                end
                PH_WDATA: begin
                    tx_base  = tx_data_i;
                    cnt_base = CNT_FULL;
                end
                PH_RDATA: begin
                    rx_base  = '0;
                    cnt_base = CNT_FULL;
                end
                PH_WACK, PH_RACK: cnt_base = CNT_ONE;
                default:          cnt_base = CNT_ZERO;
            endcase
        end
        cnt_live = (cnt_base != CNT_ZERO);
        cnt_last = (cnt_base == CNT_ONE);
        rx_shift = {rx_base[DATA_W-2:0], sda_s};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
        if (!reset_bit_i) begin
            phase_q      <= 4'd0;
            sda_o        <= 1'b1;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            ack_rx_o     <= 1'b1;
            bit_cnt_o    <= CNT_ZERO;
            phase_done_o <= 1'b0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            fin_q        <= 1'b0;
        end else begin
            phase_q      <= phase_i;
            rx_valid_o   <= 1'b0;
            phase_done_o <= 1'b0;
            bit_cnt_o    <= cnt_base;
            tx_sr        <= tx_base;
            rx_sr        <= rx_base;
            fin_q        <= fin_base;

            case (ph)
                PH_WADDR, PH_WDATA: begin
                    if (cnt_live && t_drv) begin
                        sda_o <= tx_base[DATA_W-1];
                        tx_sr <= {tx_base[DATA_W-2:0], 1'b0};
                    end
                    if (cnt_live && t_smp) begin
                        bit_cnt_o <= cnt_base - CNT_ONE;
                        if (cnt_last) begin
                            phase_done_o <= 1'b1;
                            fin_q        <= 1'b1;
                        end
                    end
                end
                PH_RDATA: begin
                    sda_o <= 1'b1;
                    if (cnt_live && t_smp) begin
                        rx_sr     <= rx_shift;
                        bit_cnt_o <= cnt_base - CNT_ONE;
                        if (cnt_last) begin
                            rx_data_o    <= rx_shift;
                            rx_valid_o   <= 1'b1;
                            phase_done_o <= 1'b1;
                            fin_q        <= 1'b1;
                        end
                    end
                end
                PH_WACK: begin
                    if (cnt_live && t_drv) sda_o <= ack_bit_i;
                    if (cnt_live && t_smp) begin
                        bit_cnt_o    <= cnt_base - CNT_ONE;
                        phase_done_o <= 1'b1;
                        fin_q        <= 1'b1;
                    end
                end
                PH_RACK: begin
                    sda_o <= 1'b1;
                    if (cnt_live && t_smp) begin
                        ack_rx_o     <= sda_s;
                        bit_cnt_o    <= cnt_base - CNT_ONE;
                        phase_done_o <= 1'b1;
                        fin_q        <= 1'b1;
                    end
                end
                PH_START: begin
                    if (t_drv) sda_o <= 1'b0;
                end
                // A finished STOP/RSTART ignores further SCL points so the bus edge is not repeated.
                PH_STOP: begin
                    if (!fin_base) begin
                        if (t_drv) sda_o <= 1'b0;
                        if (t_smp) begin
                            sda_o        <= 1'b1;
                            phase_done_o <= 1'b1;
                            fin_q        <= 1'b1;
                        end
                    end
                end
                PH_RSTART: begin
                    if (!fin_base) begin
                        if (t_drv) sda_o <= 1'b1;
                        if (t_smp) begin
                            sda_o        <= 1'b0;
                            phase_done_o <= 1'b1;
                            fin_q        <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
